// File: rtl/floor_scheduler.sv
// Single-car floor scheduler: accepts floor requests, keeps an outstanding
// request mask and serves it in SCAN order (finish the current direction,
// then reverse), holding the door open for a fixed time at each stop.
module floor_scheduler #(
  parameter int unsigned FLOOR_W     = 2,
  parameter int unsigned NUM_FLOORS  = 4,
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqValid,
  input  logic [FLOOR_W-1:0]    reqFloor,
  output logic                  reqReady,
  output logic                  reqError,
  output logic [FLOOR_W-1:0]    actualFloor,
  output logic                  down_upFlag,
  output logic                  stop_goFlag,
  output logic                  doorOpen,
  output logic [NUM_FLOORS-1:0] pendingReq
);

  localparam int unsigned MW = $clog2(MOVE_CYCLES + 1);
  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t                  state, stateNext;
  logic [FLOOR_W-1:0]      floorNext, arriveFloor;
  logic                    dirNext, errNext;
  logic [NUM_FLOORS-1:0]   pendNext, reqMask, above, below, arriveMask;
  logic [MW-1:0]           moveCnt, moveCntNext;
  logic [DW-1:0]           doorCnt, doorCntNext;
  logic                    accept, inRange, reqHere;
  logic                    anyAbove, anyBelow, atLimit, ahead, behind;

  assign reqReady    = ~rst;
  assign accept      = reqValid & reqReady;
  assign inRange     = {1'b0, reqFloor} < FLOOR_LIMIT;
  assign reqHere     = accept & inRange & (reqFloor == actualFloor);
  assign stop_goFlag = (state != MOVE);
  assign doorOpen    = (state == DOOR);
  assign arriveFloor = down_upFlag ? actualFloor + FLOOR_W'(1) : actualFloor - FLOOR_W'(1);
  assign atLimit     = down_upFlag ? (actualFloor == TOP_FLOOR) : (actualFloor == '0);
  assign anyAbove    = |above;
  assign anyBelow    = |below;
  assign ahead       = down_upFlag ? anyAbove : anyBelow;
  assign behind      = down_upFlag ? anyBelow : anyAbove;

  // Per-floor decode: incoming request, pending above/below, arrival floor.
  always_comb begin
    reqMask    = '0;
    above      = '0;
    below      = '0;
    arriveMask = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      reqMask[i]    = accept & inRange & (reqFloor == FLOOR_W'(i));
      above[i]      = pendingReq[i] & (FLOOR_W'(i) > actualFloor);
      below[i]      = pendingReq[i] & (FLOOR_W'(i) < actualFloor);
      arriveMask[i] = (FLOOR_W'(i) == arriveFloor);
    end
  end

  // Next-state logic for the car FSM, counters and request mask.
  always_comb begin
    stateNext   = state;
    floorNext   = actualFloor;
    dirNext     = down_upFlag;
    pendNext    = pendingReq | reqMask;
    moveCntNext = moveCnt;
    doorCntNext = doorCnt;
    errNext     = accept & ~inRange;
    case (state)
      IDLE: begin
        if (reqHere) begin
          pendNext    = pendingReq;
          stateNext   = DOOR;
          doorCntNext = '0;
        end else if (|pendingReq) begin
          stateNext   = MOVE;
          moveCntNext = '0;
          dirNext     = anyAbove & (down_upFlag | ~anyBelow);
        end
      end
      MOVE: begin
        if (moveCnt == MOVE_LAST) begin
          moveCntNext = '0;
          if (atLimit) begin
            // A target always lies ahead while moving; this only guards the range.
            stateNext = IDLE;
          end else begin
            floorNext = arriveFloor;
            // Same-cycle request for the arrival floor is folded in via reqMask.
            if (|((pendingReq | reqMask) & arriveMask)) begin
              pendNext    = (pendingReq | reqMask) & ~arriveMask;
              stateNext   = DOOR;
              doorCntNext = '0;
            end
          end
        end else begin
          moveCntNext = moveCnt + MW'(1);
        end
      end
      DOOR: begin
        if (reqHere) begin
          pendNext    = pendingReq;
          doorCntNext = '0;
        end else if (doorCnt == DOOR_LAST) begin
          doorCntNext = '0;
          moveCntNext = '0;
          if (ahead) begin
            stateNext = MOVE;
          end else if (behind) begin
            stateNext = MOVE;
            dirNext   = ~down_upFlag;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          doorCntNext = doorCnt + DW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      actualFloor <= '0;
      down_upFlag <= 1'b1;
      pendingReq  <= '0;
      moveCnt     <= '0;
      doorCnt     <= '0;
      reqError    <= 1'b0;
    end else begin
      state       <= stateNext;
      actualFloor <= floorNext;
      down_upFlag <= dirNext;
      pendingReq  <= pendNext;
      moveCnt     <= moveCntNext;
      doorCnt     <= doorCntNext;
      reqError    <= errNext;
    end
  end

endmodule

// File: tb/tb_floor_scheduler.sv
// Bench for floor_scheduler: a 4-floor and a 3-floor instance share stimulus
// and are each compared every cycle against a behavioural car model.
module tb_floor_scheduler;

  localparam int MOVE_CYC = 8;
  localparam int DOOR_CYC = 16;

  logic clk = 1'b0;
  logic rst, reqValid;
  logic [1:0] reqFloor;

  logic reqReady4, reqError4, up4, stop4, door4;
  logic [1:0] floor4;
  logic [3:0] pend4;
  logic reqReady3, reqError3, up3, stop3, door3;
  logic [1:0] floor3;
  logic [2:0] pend3;

  always #5 clk = ~clk;

  floor_scheduler #(.FLOOR_W(2), .NUM_FLOORS(4), .MOVE_CYCLES(MOVE_CYC), .DOOR_CYCLES(DOOR_CYC)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqFloor(reqFloor),
    .reqReady(reqReady4), .reqError(reqError4), .actualFloor(floor4),
    .down_upFlag(up4), .stop_goFlag(stop4), .doorOpen(door4), .pendingReq(pend4));

  floor_scheduler #(.FLOOR_W(2), .NUM_FLOORS(3), .MOVE_CYCLES(MOVE_CYC), .DOOR_CYCLES(DOOR_CYC)) dut3 (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqFloor(reqFloor),
    .reqReady(reqReady3), .reqError(reqError3), .actualFloor(floor3),
    .down_upFlag(up3), .stop_goFlag(stop3), .doorOpen(door3), .pendingReq(pend3));

  logic [10:0] obs4, obs3;
  assign obs4 = {reqReady4, reqError4, floor4, up4, stop4, door4, pend4};
  assign obs3 = {reqReady3, reqError3, floor3, up3, stop3, door3, 1'b0, pend3};

  // Behavioural model: remaining-time counters and a pending set.
  typedef enum {M_IDLE, M_MOVE, M_DOOR} mmode_t;
  typedef struct {
    mmode_t   mode;
    int       floor;
    bit       up;
    bit [7:0] pend;
    bit       err;
    int       left;
  } mst_t;

  mst_t m4, m3;
  int nCmp = 0;
  int nBad = 0;

  function automatic mst_t step(mst_t s, int nf, bit r, bit v, int f);
    mst_t n;
    bit hit, anyAbove, anyBelow, ahead, behind;
    n = s;
    if (r) begin
      n.mode = M_IDLE; n.floor = 0; n.up = 1'b1; n.pend = '0; n.err = 1'b0; n.left = 0;
      return n;
    end
    n.err = v && (f >= nf);
    hit = v && (f < nf);
    anyAbove = 1'b0;
    anyBelow = 1'b0;
    for (int i = 0; i < nf; i++) begin
      if (s.pend[i] && i > s.floor) anyAbove = 1'b1;
      if (s.pend[i] && i < s.floor) anyBelow = 1'b1;
    end
    case (s.mode)
      M_IDLE: begin
        if (hit && f == s.floor) begin
          n.mode = M_DOOR; n.left = DOOR_CYC;
        end else begin
          if (s.pend != 0) begin
            n.mode = M_MOVE; n.left = MOVE_CYC;
            n.up = anyAbove && (s.up || !anyBelow);
          end
          if (hit) n.pend[f] = 1'b1;
        end
      end
      M_MOVE: begin
        if (hit) n.pend[f] = 1'b1;
        n.left = s.left - 1;
        if (n.left == 0) begin
          n.floor = s.up ? s.floor + 1 : s.floor - 1;
          n.left = MOVE_CYC;
          if (n.pend[n.floor]) begin
            n.pend[n.floor] = 1'b0;
            n.mode = M_DOOR; n.left = DOOR_CYC;
          end
        end
      end
      default: begin
        if (hit && f == s.floor) begin
          n.left = DOOR_CYC;
        end else begin
          if (hit) n.pend[f] = 1'b1;
          n.left = s.left - 1;
          if (n.left == 0) begin
            ahead  = s.up ? anyAbove : anyBelow;
            behind = s.up ? anyBelow : anyAbove;
            if (ahead) begin
              n.mode = M_MOVE; n.left = MOVE_CYC;
            end else if (behind) begin
              n.mode = M_MOVE; n.left = MOVE_CYC; n.up = !s.up;
            end else begin
              n.mode = M_IDLE; n.left = 0;
            end
          end
        end
      end
    endcase
    return n;
  endfunction

  function automatic logic [10:0] expObs(mst_t s, bit r);
    return {!r, s.err, 2'(s.floor), s.up, s.mode != M_MOVE, s.mode == M_DOOR, s.pend[3:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: advance the models with the inputs present at the edge,
  // then compare both instances shortly after the edge.
  task automatic tick();
    @(posedge clk);
    m4 = step(m4, 4, rst, reqValid, int'(reqFloor));
    m3 = step(m3, 3, rst, reqValid, int'(reqFloor));
    #1;
    check("model4", obs4, expObs(m4, rst));
    check("model3", obs3, expObs(m3, rst));
  endtask

  task automatic doReset();
    rst = 1'b1; reqValid = 1'b0; reqFloor = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic request(input logic [1:0] f);
    reqValid = 1'b1; reqFloor = f;
    tick();
    reqValid = 1'b0;
  endtask

  typedef struct {
    bit rst; bit v; logic [1:0] f;
    bit eReady; bit eErr3; logic [1:0] eFloor; bit eStop; bit eDoor; logic [3:0] ePend;
  } vec_t;

  vec_t vec[6];

  initial begin
    int n, t0, t1, t2;
    bit prevDoor, lastDir, saw2;
    int stops[$];

    vec[0] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'h0};
    vec[1] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'h0};
    vec[2] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 4'h0};
    vec[3] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'h8};
    vec[4] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 4'h8};
    vec[5] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 4'h8};

    rst = 1'b1; reqValid = 1'b0; reqFloor = '0;
    m4 = '{M_IDLE, 0, 1'b1, 8'h0, 1'b0, 0};
    m3 = m4;

    // Table vectors: reset, door at current floor, out-of-range on the 3-floor car.
    for (int i = 0; i < 6; i++) begin
      rst = vec[i].rst; reqValid = vec[i].v; reqFloor = vec[i].f;
      tick();
      check($sformatf("vec%0d.ready", i), reqReady4, vec[i].eReady);
      check($sformatf("vec%0d.err3", i), reqError3, vec[i].eErr3);
      check($sformatf("vec%0d.floor", i), floor4, vec[i].eFloor);
      check($sformatf("vec%0d.stop", i), stop4, vec[i].eStop);
      check($sformatf("vec%0d.door", i), door4, vec[i].eDoor);
      check($sformatf("vec%0d.pend", i), pend4, vec[i].ePend);
      check($sformatf("vec%0d.pend3", i), pend3, 3'b000);
    end
    reqValid = 1'b0;

    // Reset held two cycles in the middle of a move, with a request alongside.
    doReset();
    request(2'd3);
    repeat (5) tick();
    check("rst.moving", stop4, 1'b0);
    rst = 1'b1; reqValid = 1'b1; reqFloor = 2'd2;
    tick();
    check("rst.ready", reqReady4, 1'b0);
    check("rst.floor", floor4, 2'd0);
    check("rst.dir", up4, 1'b1);
    check("rst.stop", stop4, 1'b1);
    check("rst.door", door4, 1'b0);
    check("rst.err", reqError4, 1'b0);
    check("rst.pend", pend4, 4'h0);
    tick();
    rst = 1'b0; reqValid = 1'b0;
    tick();
    check("rst.discard", pend4, 4'h0);
    check("rst.idle", stop4, 1'b1);

    // Floor 0 to floor 2: travel times and door length.
    doReset();
    request(2'd2);
    n = 0;
    while (floor4 != 2'd1 && n < 200) begin tick(); n++; end
    check("trip.toFloor1", n, 9);
    n = 0;
    while (floor4 != 2'd2 && n < 200) begin tick(); n++; end
    check("trip.toFloor2", n, MOVE_CYC);
    check("trip.doorAtArrive", door4, 1'b1);
    n = 0;
    while (door4 && n < 100) begin n++; tick(); end
    check("trip.doorLen", n, DOOR_CYC);
    check("trip.idle", stop4, 1'b1);
    check("trip.pend", pend4, 4'h0);

    // Door hold-open by re-requesting the current floor.
    doReset();
    request(2'd1);
    n = 0;
    while (!(floor4 == 2'd1 && !door4 && stop4 && pend4 == 4'h0) && n < 300) begin tick(); n++; end
    check("hold.reachIdle", (n < 300), 1'b1);
    request(2'd1);
    check("hold.open", door4, 1'b1);
    check("hold.noPend", pend4, 4'h0);
    repeat (9) tick();
    check("hold.cycle10", door4, 1'b1);
    request(2'd1);
    n = 0;
    while (door4 && n < 100) begin n++; tick(); end
    check("hold.further", n, DOOR_CYC);

    // SCAN order: at floor 1 heading to 3, requests for 0 and 2.
    request(2'd3);
    tick();
    check("scan.goingUp", {stop4, up4}, 2'b01);
    request(2'd0);
    request(2'd2);
    n = 0; prevDoor = 1'b0; lastDir = 1'b1;
    while (n < 800 && !(stops.size() == 3 && stop4 && !door4)) begin
      if (door4 && !prevDoor) begin
        stops.push_back(int'(floor4));
        lastDir = up4;
      end
      prevDoor = door4;
      tick(); n++;
    end
    t0 = (stops.size() > 0) ? stops[0] : -1;
    t1 = (stops.size() > 1) ? stops[1] : -1;
    t2 = (stops.size() > 2) ? stops[2] : -1;
    check("scan.nStops", stops.size(), 3);
    check("scan.stop1", t0, 2);
    check("scan.stop2", t1, 3);
    check("scan.stop3", t2, 0);
    check("scan.reversed", lastDir, 1'b0);
    check("scan.pend", pend4, 4'h0);

    // Request for floor 2 in the very cycle the car arrives there on the way to 3.
    doReset();
    request(2'd3);
    repeat (16) tick();
    check("arrive.floor1", floor4, 2'd1);
    request(2'd2);
    check("arrive.floor2", floor4, 2'd2);
    check("arrive.door", door4, 1'b1);
    check("arrive.pend", pend4, 4'h8);
    n = 0; saw2 = 1'b0;
    while (!(floor4 == 2'd3 && stop4 && !door4) && n < 300) begin
      tick(); n++;
      if (pend4[2]) saw2 = 1'b1;
    end
    check("arrive.never2", saw2, 1'b0);
    check("arrive.floor3", floor4, 2'd3);

    // Randomized traffic against the model, with occasional resets.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(99) == 0);
      reqValid = ($urandom_range(4) == 0);
      if ($urandom_range(3) == 0) reqFloor = 2'(m4.floor);
      else reqFloor = 2'($urandom_range(3));
      tick();
    end
    rst = 1'b0; reqValid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/floor_scheduler.md
FLOOR_SCHEDULER -- requirements
Module: floor_scheduler

Interface
REQ-001 Parameter FLOOR_W, default 2, floor index width.
REQ-002 Parameter NUM_FLOORS, default 4, served floors 0..NUM_FLOORS-1; SHALL satisfy 2 <= NUM_FLOORS <= 2^FLOOR_W.
REQ-003 Parameter MOVE_CYCLES, default 8, clock cycles per one-floor travel (>=1).
REQ-004 Parameter DOOR_CYCLES, default 16, clock cycles door held open (>=1).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 reqValid  in  1  floor request strobe.
REQ-008 reqFloor  in  FLOOR_W  requested floor.
REQ-009 reqReady  out  1  request accept; 1 whenever rst=0; accept = reqValid & reqReady.
REQ-010 reqError  out  1  one-cycle pulse, out-of-range request dropped.
REQ-011 actualFloor  out  FLOOR_W  current floor.
REQ-012 down_upFlag  out  1  travel direction: 1 up, 0 down.
REQ-013 stop_goFlag  out  1  1 = car stationary, 0 = moving.
REQ-014 doorOpen  out  1  door open.
REQ-015 pendingReq  out  NUM_FLOORS  registered outstanding-request bitmask.

Function
REQ-016 FSM states SHALL be IDLE, MOVE, DOOR; stop_goFlag = 1 in IDLE/DOOR, 0 in MOVE; doorOpen = 1 only in DOOR.
REQ-017 Accepted request with reqFloor >= NUM_FLOORS SHALL be dropped and pulse reqError the following cycle; pendingReq unchanged.
REQ-018 Accepted in-range request SHALL set pendingReq[reqFloor] at the next edge, except REQ-019/REQ-020 cases.
REQ-019 Request for actualFloor in IDLE SHALL enter DOOR at next edge without setting pending.
REQ-020 Request for actualFloor in DOOR SHALL reload door counter (hold-open) without setting pending.
REQ-021 IDLE with pendingReq != 0: next edge enters MOVE; direction = up if pending above and (down_upFlag=1 or none pending below), else down.
REQ-022 MOVE: counter counts cycles in MOVE; on MOVE_CYCLES-th cycle, actualFloor +/-1 per down_upFlag, counter cleared.
REQ-023 On arrival, if pendingReq[new floor] = 1 (including same-cycle accepted request for that floor) SHALL clear bit and enter DOOR; else remain MOVE.
REQ-024 actualFloor SHALL never leave 0..NUM_FLOORS-1; direction SHALL only change in IDLE/DOOR.
REQ-025 DOOR lasts DOOR_CYCLES cycles after last load; on expiry: pending in current direction -> MOVE same direction; else pending opposite -> MOVE, direction reversed; else IDLE, direction held.
REQ-026 Request accepted while MOVE/DOOR for any other floor SHALL only set its pending bit (SCAN order, no preemption).

Reset
REQ-027 rst=1 at an edge SHALL, regardless of state: FSM IDLE, actualFloor 0, down_upFlag 1, stop_goFlag 1, doorOpen 0, reqError 0, pendingReq 0, counters 0; reqReady 0 while rst=1.
REQ-028 Request asserted in same cycle as rst SHALL be discarded.

Verification (defaults unless stated)
REQ-029 Reset: rst high 2 cycles mid-MOVE -> all outputs at REQ-027 values on next edge.
REQ-030 Idle floor 0, request 2 -> MOVE; actualFloor 1 after 8 MOVE cycles, 2 after 16; doorOpen 16 cycles; IDLE, pendingReq 0.
REQ-031 At floor 1 moving up to 3, requests 0 and 2 -> stops at 2, then 3, then reverses (down_upFlag 0), stops at 0.
REQ-032 Idle floor 1, request 1 -> doorOpen next cycle; re-request 1 at door cycle 10 -> door stays open 16 further cycles.
REQ-033 NUM_FLOORS=3, request 3 -> reqError one-cycle pulse, pendingReq 0, state IDLE.
REQ-034 Request for floor 2 arriving exact cycle car reaches 2 en route to 3 -> stop at 2, bit 2 never remains set.
